rx_record_assembler: RTL
========================

Name: rx_record_assembler

Overview:
- Packs a UART RX byte stream into fixed-size records and issues one memory write per record.
- A zero byte in record position 0 terminates the stream.
- In read mode it steps a read pointer through the stored records.
- Sits between the UART receiver and the matrix memory. It is the parametrised successor of the byte-collecting control unit, adding configurable record width and depth, full and overflow detection, and a read handshake.

Parameters:
- BYTES_PER_REC, 8, bytes per record (default: four 16-bit values); range 1..16.
- ADDR_W, 16, width of the write and read pointers.
- DEPTH, 1024, maximum records stored; must satisfy DEPTH <= 2**ADDR_W - 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; clears pointers and flags and begins a new stream.
- wen  in  1  mode select: 1 = load (accept bytes), 0 = read (accept readReq).
- dataReady  in  1  inByte valid strobe; one byte is accepted per cycle it is high.
- inByte  in  8  received byte.
- readReq  in  1  read-mode request to advance one record.
- memWrite  out  1  one-cycle write strobe to memory.
- memData  out  8*BYTES_PER_REC  assembled record.
- writePtr  out  ADDR_W  write address while memWrite is high; otherwise the count of stored records.
- readPtr  out  ADDR_W  read address.
- readValid  out  1  one-cycle pulse; readPtr is a valid address in this cycle.
- done  out  1  level; the terminator has been received.
- overflow  out  1  sticky; a record was dropped because storage was full.

Behaviour:
- Single clock. All outputs are registered.
- reset (and start, identically):
  - state = IDLE; memWrite=0, memData=0, writePtr=0, readPtr=0, readValid=0, done=0, overflow=0.
  - Internal byte counter = 0; the assembly buffer is cleared.
  - reset has priority over start. start has priority over all other inputs in the same cycle.
- States IDLE, COLLECT, DONE:
  - IDLE, wen & dataReady & inByte==0 -> DONE; done<=1; no write.
  - IDLE, wen & dataReady & inByte!=0 -> COLLECT; the byte is stored at position 0; counter=1.
  - COLLECT, wen & dataReady: the byte is stored at position counter; counter increments. Zero bytes at positions 1..BYTES_PER_REC-1 are data, not terminators.
  - COLLECT, on accepting byte BYTES_PER_REC-1: the full record is committed (see below); counter=0; -> IDLE.
  - COLLECT, wen==0: the partial record is discarded; counter=0; -> IDLE. No write occurs.
  - DONE: dataReady is ignored. Only reset or start leaves DONE (-> IDLE).
- Byte packing: little-endian. Byte k occupies memData[8k+7:8k].
- Commit timing, with the last byte sampled at edge N:
  - memData is loaded with the full record at edge N.
  - If writePtr<DEPTH: memWrite=1 for the cycle N..N+1, holding the current writePtr; writePtr increments at edge N+1.
  - If writePtr==DEPTH: no memWrite; overflow<=1; writePtr holds.
- Back-to-back bytes need no stall. A byte accepted at edge N+1 starts the next record in the assembly buffer, separate from memData. memData is reloaded only at the next commit.
- writePtr saturates at DEPTH and never wraps.
- Read side, active only when wen==0 (state unchanged):
  - readReq while readPtr<writePtr: readValid=1 for the next cycle with readPtr unchanged; readPtr increments at the edge ending that cycle.
  - readReq while readPtr==writePtr (empty/exhausted): ignored; readValid stays 0.
  - readReq during the readValid cycle is ignored, so requests are accepted at most every second cycle.
- Mode gating:
  - readReq is ignored while wen==1.
  - dataReady is ignored while wen==0.
  - Both asserted together: only the one matching wen acts.
- Reset mid-record or mid-read: all progress is lost; memWrite and readValid drop on the following cycle.

Test Plan:
- BYTES_PER_REC=8: send 01..08 back-to-back, then 00 -> one memWrite, writePtr=0 during the strobe, memData=64'h0807060504030201; then writePtr=1, done=1.
- Send 00 as the first byte -> done=1, memWrite never asserts, writePtr=0; further bytes are ignored until start.
- Send 16 bytes with dataReady every cycle -> memWrite pulses at writePtr 0 and 1, eight cycles apart; second memData=64'h100F0E0D0C0B0A09.
- Send 3 bytes, drop wen, raise wen, send 8 bytes AA..B1 -> exactly one write, memData=64'hB1B0AFAEADACABAA.
- DEPTH=2: send 3 full records -> two memWrites; overflow=1 after the third; writePtr=2.
- After 3 records stored, wen=0, readReq held high for 10 cycles -> readValid pulses at readPtr 0, 1, 2 on alternate cycles, then stays 0; readPtr=3.

Source files
------------

// File: rtl/rx_record_assembler.sv
// Packs a UART RX byte stream into fixed-size little-endian records, one memory write per record,
// with a zero byte at record position 0 ending the stream and a handshaked read pointer for playback.
module rx_record_assembler #(
    parameter int BYTES_PER_REC = 8,
    parameter int ADDR_W        = 16,
    parameter int DEPTH         = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       wen,
    input  logic                       dataReady,
    input  logic [7:0]                 inByte,
    input  logic                       readReq,
    output logic                       memWrite,
    output logic [8*BYTES_PER_REC-1:0] memData,
    output logic [ADDR_W-1:0]          writePtr,
    output logic [ADDR_W-1:0]          readPtr,
    output logic                       readValid,
    output logic                       done,
    output logic                       overflow
);

    localparam int                REC_W   = 8 * BYTES_PER_REC;
    localparam int                CNT_W   = (BYTES_PER_REC > 1) ? $clog2(BYTES_PER_REC) : 1;
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(BYTES_PER_REC - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [REC_W-1:0]  asm_buf;
    logic [REC_W-1:0]  rec_next;
    logic [ADDR_W-1:0] wr_count;
    logic              accept;
    logic              terminate;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        rec_next = asm_buf;
        rec_next[{cnt, 3'b000} +: 8] = inByte;
    end

    // Record count including a write strobed this cycle, so back-to-back commits and reads see it.
    assign wr_count  = memWrite ? writePtr + ADDR_W'(1) : writePtr;
    assign accept    = wen && dataReady &&
                       (state == COLLECT || (state == IDLE && inByte != 8'd0));
    assign terminate = wen && dataReady && state == IDLE && inByte == 8'd0;

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            state     <= IDLE;
            cnt       <= '0;
            asm_buf   <= '0;
            memWrite  <= 1'b0;
            memData   <= '0;
            writePtr  <= '0;
            readPtr   <= '0;
            readValid <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            memWrite  <= 1'b0;
            readValid <= 1'b0;
            if (memWrite)
                writePtr <= writePtr + ADDR_W'(1);
            if (readValid)
                readPtr <= readPtr + ADDR_W'(1);

            case (state)
                IDLE: if (terminate) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                COLLECT: if (!wen) begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: ;
            endcase

            if (accept) begin
                asm_buf <= rec_next;
                if (cnt == LAST) begin
                    cnt     <= '0;
                    state   <= IDLE;
                    memData <= rec_next;
                    if (wr_count < DEPTH_A)
                        memWrite <= 1'b1;
                    else
                        overflow <= 1'b1;
                end else begin
                    cnt   <= cnt + CNT_W'(1);
                    state <= COLLECT;
                end
            end

            // A request during the readValid cycle is dropped, pacing reads to every second cycle.
            if (!wen && readReq && !readValid && readPtr < wr_count)
                readValid <= 1'b1;
        end
    end

endmodule
